// File: rtl/store_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// store_rmw_ctrl
//
// Single-outstanding load/store controller sitting between a core and a
// word-wide memory. Word stores go straight to memory. Loads read one word and
// extract/extend the addressed lane(s). Sub-word stores do a read-modify-write:
// read the containing word, merge the new byte/half into it, then write the
// whole word back. Misaligned or illegal-size requests complete immediately
// with an error and never touch memory.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   req_valid/ready : request handshake (ready only while idle)
//   req_we          : 1 = store, 0 = load
//   req_size        : 00 word, 01 half, 10 byte, 11 illegal
//   req_unsigned    : load zero-extends when 1, sign-extends when 0
//   req_addr        : byte address
//   req_wdata       : store data, sub-word data right-aligned
//   rsp_valid       : one-cycle completion pulse
//   rsp_rdata       : extended load data (0 for stores and errors)
//   rsp_err         : misaligned / illegal-size request
//   mem_addr        : word-aligned memory address (bits [1:0] = 00)
//   mem_re, mem_we  : one-cycle read / write strobes, never together
//   mem_wdata       : full word to write
//   mem_rdata       : read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module store_rmw_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Size 11 is always illegal; halves need an even address, words need a
  // 4-byte aligned address. Bytes are legal anywhere.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_WORD: bad = (off != 2'b00);
      SIZE_HALF: bad = off[0];
      SIZE_BYTE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Overlay the store data onto the word read back from memory. Lanes not
  // covered by the store keep the read data. A word store replaces everything.
  function automatic logic [31:0] merge_word(input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [31:0] rd,
                                             input logic [31:0] wd);
    logic [31:0] m;
    m = rd;
    case (size)
      SIZE_HALF: begin
        if (off[1]) m[31:16] = wd[15:0];
        else        m[15:0]  = wd[15:0];
      end
      SIZE_BYTE: begin
        case (off)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  // Shift the addressed lane(s) down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] extract_load(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns,
                                               input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> {off, 3'b000};
    case (size)
      SIZE_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
      SIZE_BYTE: res = {{24{~uns & sh[7]}},  sh[7:0]};
      default:   res = rd;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic              ready_q,     ready_d;

  // Request fields latched at acceptance; only the byte offset of the address
  // is needed afterwards because mem_addr is loaded at acceptance.
  logic              we_q,        we_d;
  logic [1:0]        size_q,      size_d;
  logic              uns_q,       uns_d;
  logic [1:0]        off_q,       off_d;
  logic [31:0]       wdata_q,     wdata_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_re_q,    mem_re_d;
  logic              mem_we_q,    mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [ADDR_W-1:0] req_addr_aligned;
  assign req_addr_aligned = {req_addr[ADDR_W-1:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Next-state logic. All outputs are registered: each output's value for a
  // state is loaded on the edge that enters that state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default here first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Strobes and response fields are single-cycle: cleared unless the
    // transition below re-asserts them.
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          if (is_bad_req(req_size, req_addr[1:0])) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_size == SIZE_WORD) begin
            // Full-word store needs no read-back.
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr_aligned;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = S_READ;
            mem_re_d   = 1'b1;
            mem_addr_d = req_addr_aligned;
          end
        end
      end

      S_READ: begin
        // Read strobe was this cycle; data arrives during MERGE.
        state_d = S_MERGE;
      end

      S_MERGE: begin
        if (we_q) begin
          state_d     = S_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_word(size_q, off_q, mem_rdata, wdata_q);
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = extract_load(size_q, off_q, uns_q, mem_rdata);
        end
      end

      S_WRITE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= SIZE_WORD;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for store_rmw_ctrl: directed vector table, reset corner cases,
// and randomized traffic against a byte-level memory reference model.
// -----------------------------------------------------------------------------
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  store_rmw_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Memory environment: word store keyed by aligned address, a monitor that
  // counts strobes, and a read driver that presents data only in the cycle
  // after mem_re (garbage otherwise).
  // ---------------------------------------------------------------------------
  logic [31:0] mem_words [bit [31:0]];
  int          re_cnt   = 0;
  int          we_cnt   = 0;
  int          both_cnt = 0;
  logic [31:0] re_addr  = 32'h0;
  logic [31:0] we_addr  = 32'h0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (mem_re) begin
      re_cnt++;
      re_addr = mem_addr;
    end
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      mem_words[mem_addr] = mem_wdata;
    end
    if (mem_re && mem_we) both_cnt++;
  end

  always @(negedge clk) begin
    logic [31:0] d;
    if (mem_re) begin
      d = mem_read(mem_addr);
      @(posedge clk);
      #1 mem_rdata = d;
      @(posedge clk);
      #1 mem_rdata = $urandom;
    end
  end

  // ---------------------------------------------------------------------------
  // One transaction. Called at a negedge while idle; returns at the negedge
  // after the response, with the idle state checked. While busy, req_valid
  // stays high with junk fields to confirm they are ignored.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input  logic        we,
                         input  logic [1:0]  size,
                         input  logic        uns,
                         input  logic [31:0] addr,
                         input  logic [31:0] wdata,
                         output int          lat,
                         output logic        err,
                         output logic [31:0] rdata);
    int          cyc;
    logic        done;
    logic [31:0] rnd;
    check("ready_before_req", 32'(req_ready), 32'd1);
    re_cnt       = 0;
    we_cnt       = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    done  = 1'b0;
    lat   = -1;
    err   = 1'b0;
    rdata = 32'h0;
    cyc   = 0;
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        done  = 1'b1;
        lat   = cyc;
        err   = rsp_err;
        rdata = rsp_rdata;
      end else begin
        rnd          = $urandom;
        req_we       = rnd[0];
        req_size     = rnd[2:1];
        req_unsigned = rnd[3];
        req_addr     = $urandom;
        req_wdata    = $urandom;
      end
    end
    req_valid = 1'b0;
    check("rsp_seen", 32'(done), 32'd1);
    @(negedge clk);
    check("after_rsp_flags", {29'h0, rsp_valid, rsp_err, req_ready}, 32'h1);
    check("after_rsp_rdata", rsp_rdata, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;    // memory word before the access
    logic        err;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] post;   // memory word after the access
    int          nre;
    int          nwe;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  // Byte-level reference memory for the random phase (words 0x400..0x43C).
  logic [7:0] ref_mem [64];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] aligned;
    logic [31:0] pre;
    logic [31:0] rnd;
    int          seen;
    vec_t        v;

    //             we    size   uns   addr        wdata         pre           err   lat rdata         post          re we
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h103, 32'h0000_00AB, 32'h1122_3344, 1'b0, 4, 32'h0,        32'hAB22_3344, 1, 1};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h100, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 4, 32'h0,        32'h1122_BEEF, 1, 1};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, 32'h1122_3344, 1'b0, 4, 32'h0,        32'hBEEF_3344, 1, 1};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0,         32'h1122_8044, 1'b0, 3, 32'hFFFF_FF80, 32'h1122_8044, 1, 0};
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 32'h101, 32'h0,         32'h1122_8044, 1'b0, 3, 32'h0000_0080, 32'h1122_8044, 1, 0};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h101, 32'h0000_BEEF, 32'h1122_3344, 1'b1, 1, 32'h0,        32'h1122_3344, 0, 0};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h5555_5555, 1'b0, 2, 32'h0,        32'hDEAD_BEEF, 0, 1};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h204, 32'h0,         32'h89AB_CDEF, 1'b0, 3, 32'h89AB_CDEF, 32'h89AB_CDEF, 1, 0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h206, 32'h0,         32'h8001_7FFF, 1'b0, 3, 32'hFFFF_8001, 32'h8001_7FFF, 1, 0};
    vecs[9]  = '{1'b1, 2'b11, 1'b0, 32'h300, 32'h1234_5678, 32'hCAFE_F00D, 1'b1, 1, 32'h0,        32'hCAFE_F00D, 0, 0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h302, 32'h0,         32'hCAFE_F00D, 1'b1, 1, 32'h0,        32'hCAFE_F00D, 0, 0};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFF_FF5A, 32'h1122_3344, 1'b0, 4, 32'h0,        32'h1122_335A, 1, 1};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0,         32'h8001_0000, 1'b0, 3, 32'h0000_8001, 32'h8001_0000, 1, 0};

    for (int w = 0; w < 16; w++) begin
      rnd = $urandom;
      mem_words[32'h400 + 32'(4 * w)] = rnd;
      for (int b = 0; b < 4; b++) ref_mem[4 * w + b] = rnd[8 * b +: 8];
    end

    // ---- reset state ------------------------------------------------------
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_rdata    = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {28'h0, mem_re, mem_we, rsp_valid, rsp_err}, 32'h0);
    check("reset_rdata",   rsp_rdata, 32'h0);
    check("reset_wdata",   mem_wdata, 32'h0);
    check("reset_addr",    mem_addr,  32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);

    // ---- directed vectors -------------------------------------------------
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      aligned = v.addr & ~32'h3;
      mem_words[aligned] = v.pre;
      run_txn(v.we, v.size, v.uns, v.addr, v.wdata, lat, err, rdata);
      check($sformatf("v%0d_latency", i), lat, v.lat);
      check($sformatf("v%0d_err", i),     32'(err), 32'(v.err));
      check($sformatf("v%0d_rdata", i),   rdata, v.rdata);
      check($sformatf("v%0d_re_count", i), re_cnt, v.nre);
      check($sformatf("v%0d_we_count", i), we_cnt, v.nwe);
      check($sformatf("v%0d_mem_word", i), mem_read(aligned), v.post);
      if (v.nre != 0) check($sformatf("v%0d_re_addr", i), re_addr, aligned);
      if (v.nwe != 0) check($sformatf("v%0d_we_addr", i), we_addr, aligned);
    end

    // ---- reset while a byte store is in MERGE ------------------------------
    pre    = mem_read(32'h100);
    re_cnt = 0;
    we_cnt = 0;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h103;
    req_wdata    = 32'h0000_00AB;
    @(posedge clk);
    @(negedge clk);              // READ
    req_valid = 1'b0;
    check("rm_read_strobe", 32'(mem_re), 32'd1);
    @(negedge clk);              // MERGE
    reset = 1'b1;
    @(negedge clk);
    check("rm_reset_strobes", {28'h0, mem_re, mem_we, rsp_valid, rsp_err}, 32'h0);
    check("rm_reset_wdata",   mem_wdata, 32'h0);
    check("rm_reset_addr",    mem_addr,  32'h0);
    check("rm_reset_rdata",   rsp_rdata, 32'h0);
    reset = 1'b0;
    seen  = 0;
    @(negedge clk);
    check("rm_ready_after", 32'(req_ready), 32'd1);
    repeat (4) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("rm_no_rsp",   seen,   0);
    check("rm_no_we",    we_cnt, 0);
    check("rm_mem_same", mem_read(32'h100), pre);

    // ---- reset beats a concurrent request ---------------------------------
    re_cnt       = 0;
    we_cnt       = 0;
    reset        = 1'b1;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b00;
    req_addr     = 32'h500;
    req_wdata    = 32'h1234_5678;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    seen      = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || mem_we || mem_re) seen++;
    end
    check("rp_no_activity", seen, 0);
    check("rp_no_we",       we_cnt, 0);
    check("rp_ready",       32'(req_ready), 32'd1);

    // ---- randomized traffic vs byte-level reference -----------------------
    for (int t = 0; t < 200; t++) begin
      logic        we, uns, exp_err;
      logic [1:0]  size;
      int          sel, off, n, base, exp_lat, exp_re, exp_we;
      logic [31:0] addr, wdata, exp_rdata, exp_word;
      logic [63:0] val, mask;

      rnd   = $urandom;
      we    = rnd[0];
      uns   = rnd[1];
      sel   = $urandom_range(0, 9);
      size  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      off   = $urandom_range(0, 63);
      addr  = 32'h400 + 32'(off);
      wdata = $urandom;
      n     = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
      base  = off - (off % 4);

      exp_err   = (size == 2'b11) || ((off % n) != 0);
      exp_rdata = 32'h0;
      exp_re    = 0;
      exp_we    = 0;
      exp_lat   = 1;
      if (!exp_err) begin
        if (we) begin
          for (int b = 0; b < n; b++) ref_mem[off + b] = wdata[8 * b +: 8];
          exp_lat = (n == 4) ? 2 : 4;
          exp_re  = (n == 4) ? 0 : 1;
          exp_we  = 1;
        end else begin
          val = 64'h0;
          for (int b = 0; b < n; b++) val = val | (64'(ref_mem[off + b]) << (8 * b));
          mask = (64'h1 << (8 * n)) - 64'h1;
          if (!uns && val[8 * n - 1]) val = val | ~mask;
          exp_rdata = val[31:0];
          exp_lat   = 3;
          exp_re    = 1;
        end
      end
      exp_word = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};

      run_txn(we, size, uns, addr, wdata, lat, err, rdata);
      check($sformatf("r%0d_latency", t),  lat, exp_lat);
      check($sformatf("r%0d_err", t),      32'(err), 32'(exp_err));
      check($sformatf("r%0d_rdata", t),    rdata, exp_rdata);
      check($sformatf("r%0d_re_count", t), re_cnt, exp_re);
      check($sformatf("r%0d_we_count", t), we_cnt, exp_we);
      check($sformatf("r%0d_mem_word", t), mem_read(32'h400 + 32'(base)), exp_word);
    end

    check("no_re_we_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_rmw_ctrl.md
STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width.
REQ-002 Port: clk input 1, single clock; all state updates on rising edge.
REQ-003 Port: reset input 1, synchronous, active-high.
REQ-004 Port: req_valid input 1, core has a memory access pending.
REQ-005 Port: req_ready output 1, controller accepts a request this cycle.
REQ-006 Port: req_we input 1, 1 = store, 0 = load.
REQ-007 Port: req_size input 2, 00 word, 01 half, 10 byte, 11 illegal.
REQ-008 Port: req_unsigned input 1, load zero-extends when 1, sign-extends when 0.
REQ-009 Port: req_addr input ADDR_W, byte address.
REQ-010 Port: req_wdata input 32, store data, sub-word data right-aligned in low bits.
REQ-011 Port: rsp_valid output 1, one-cycle completion pulse.
REQ-012 Port: rsp_rdata output 32, extended load result; 0 for stores and errors.
REQ-013 Port: rsp_err output 1, valid with rsp_valid; misaligned or illegal-size request.
REQ-014 Port: mem_addr output ADDR_W, word-aligned address, bits [1:0] always 00.
REQ-015 Port: mem_re output 1, read strobe.
REQ-016 Port: mem_we output 1, write strobe.
REQ-017 Port: mem_wdata output 32, full word to write.
REQ-018 Port: mem_rdata input 32, read data, valid exactly one cycle after the mem_re cycle.

Function
REQ-019 FSM states SHALL be IDLE, READ, MERGE, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-020 Acceptance: req_valid && req_ready at an edge latches all req_* fields; req_* are ignored in every other state.
REQ-021 Error check at acceptance: size 11, half with addr[0]=1, or word with addr[1:0]!=00 -> RESP with rsp_err=1; no mem_re, no mem_we.
REQ-022 IDLE transitions: word store -> WRITE; load or sub-word store -> READ; error -> RESP.
REQ-023 READ: mem_re=1 and mem_addr = latched addr with [1:0] forced to 00 for one cycle -> MERGE.
REQ-024 MERGE: capture mem_rdata; sub-word store -> WRITE; load -> RESP.
REQ-025 Merge rule: half replaces byte lanes {off+1,off} (off = addr[1:0], 0 or 2) with wdata[15:0]; byte replaces lane off with wdata[7:0]; other lanes keep captured read data.
REQ-026 WRITE: mem_we=1 for exactly one cycle, mem_wdata = merged word (word store: latched wdata) -> RESP.
REQ-027 Load extraction: half = rdata[8*off+15 : 8*off]; byte = rdata[8*off+7 : 8*off]; word = rdata; sign- or zero-extend per req_unsigned.
REQ-028 RESP: rsp_valid=1 for one cycle, then IDLE; rsp_rdata/rsp_err SHALL be held stable in RESP and driven 0 elsewhere.
REQ-029 Latency from acceptance edge to rsp_valid cycle: word store 2, load 3, sub-word store 4, error 1 cycles.
REQ-030 Back-to-back: a new request SHALL be accepted no earlier than the cycle after RESP; the controller SHALL never have two requests in flight.
REQ-031 mem_re and mem_we SHALL never be asserted in the same cycle; outside READ/WRITE both are 0 and mem_addr holds the last value.

Reset
REQ-032 reset=1 at an edge forces IDLE; all outputs (rsp_valid, rsp_err, rsp_rdata, mem_re, mem_we, mem_wdata, mem_addr) = 0 next cycle; req_ready=1 after reset deasserts.
REQ-033 Reset mid-operation (READ/MERGE/WRITE) aborts the access with no mem_we issued and no rsp_valid pulse.
REQ-034 reset takes priority over a concurrent req_valid; that request is not accepted.

Verification
REQ-035 Byte store addr 0x103, wdata 0xAB, memory word 0x11223344 -> mem_we once, mem_wdata 0xAB223344, rsp_valid 4 cycles after acceptance, rsp_err 0.
REQ-036 Half store addr 0x100, wdata 0xBEEF over 0x11223344 -> mem_wdata 0x1122BEEF; addr 0x102 -> 0xBEEF3344.
REQ-037 Signed byte load addr 0x101 from 0x11228044 -> rsp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080; latency 3.
REQ-038 Half store addr 0x101 -> rsp_valid with rsp_err 1 one cycle after acceptance, mem_re and mem_we never asserted.
REQ-039 Word store addr 0x200, wdata 0xDEADBEEF -> no mem_re, mem_we with 0xDEADBEEF, rsp_valid 2 cycles after acceptance.
REQ-040 Reset asserted in MERGE of a byte store -> mem_we stays 0, no rsp_valid, req_ready=1 the cycle after reset deasserts.
